// File: rtl/ad1_sample_ctrl.sv
// ad1_sample_ctrl -- periodic two-channel ADC sampling controller.
// A free-running tick (period DIV while enabled) launches a request/acknowledge
// handshake with the converter. The request is abandoned after TMO cycles
// without an acknowledge. Ticks that land mid-handshake are counted as overruns.
// Optional feature macro: AD1_AVG_EN -- when defined, four captures are averaged
// per channel before a sample is presented.
module ad1_sample_ctrl #(
  parameter int unsigned DIV = 200,
  parameter int unsigned TMO = 100
) (
  input  logic        bufclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clrflags,
  output logic        adcdav,
  input  logic        davadc,
  input  logic [11:0] adc0data,
  input  logic [11:0] adc1data,
  output logic [11:0] sample0,
  output logic [11:0] sample1,
  output logic        smpvalid,
  output logic        overrun,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [7:0]  TMO_LAST = 8'(TMO - 1);

  state_t      state_q, state_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]  wait_q, wait_d;
  logic        adcdav_q, adcdav_d;
  logic        smpvalid_q, smpvalid_d;
  logic        overrun_q, overrun_d;
  logic        timeout_q, timeout_d;
  logic [11:0] sample0_q, sample0_d;
  logic [11:0] sample1_q, sample1_d;
  logic        tick;
  logic        capture;
  logic        tmo_evt;

  // Sample-period counter: runs only while enabled, tick on its last count.
  always_comb begin
    tick       = enable && (tick_cnt_q == DIV_LAST);
    tick_cnt_d = tick_cnt_q + 16'd1;
    if (!enable || tick) begin
      tick_cnt_d = 16'd0;
    end
  end

  // Handshake FSM; the request line is the registered image of the REQ state.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    capture = 1'b0;
    tmo_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = REQ;
          wait_d  = 8'd0;
        end
      end
      REQ: begin
        if (davadc) begin
          capture = 1'b1;
          state_d = RELEASE;
        end else if (wait_q == TMO_LAST) begin
          tmo_evt = 1'b1;
          state_d = RELEASE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      RELEASE: begin
        if (!davadc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    adcdav_d = (state_d == REQ);
  end

  // Sticky flags: a set event in the same cycle as clrflags keeps the flag set.
  always_comb begin
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    if (clrflags) begin
      overrun_d = 1'b0;
      timeout_d = 1'b0;
    end
    if (tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
    if (tmo_evt) begin
      timeout_d = 1'b1;
    end
  end

`ifdef AD1_AVG_EN
  logic [13:0] acc0_q, acc0_d;
  logic [13:0] acc1_q, acc1_d;
  logic [1:0]  cap_cnt_q, cap_cnt_d;
  logic [13:0] sum0, sum1;

  // Four-capture averaging; the fourth capture folds in and publishes (acc+new)>>2.
  always_comb begin
    sum0       = acc0_q + {2'b00, adc0data};
    sum1       = acc1_q + {2'b00, adc1data};
    acc0_d     = acc0_q;
    acc1_d     = acc1_q;
    cap_cnt_d  = cap_cnt_q;
    sample0_d  = sample0_q;
    sample1_d  = sample1_q;
    smpvalid_d = 1'b0;
    if (capture) begin
      if (cap_cnt_q == 2'd3) begin
        sample0_d  = sum0[13:2];
        sample1_d  = sum1[13:2];
        smpvalid_d = 1'b1;
        acc0_d     = 14'd0;
        acc1_d     = 14'd0;
        cap_cnt_d  = 2'd0;
      end else begin
        acc0_d    = sum0;
        acc1_d    = sum1;
        cap_cnt_d = cap_cnt_q + 2'd1;
      end
    end else if (!enable && (state_q == IDLE)) begin
      acc0_d    = 14'd0;
      acc1_d    = 14'd0;
      cap_cnt_d = 2'd0;
    end
  end

  // Averaging state registers.
  always_ff @(posedge bufclk) begin
    if (reset) begin
      acc0_q    <= 14'd0;
      acc1_q    <= 14'd0;
      cap_cnt_q <= 2'd0;
    end else begin
      acc0_q    <= acc0_d;
      acc1_q    <= acc1_d;
      cap_cnt_q <= cap_cnt_d;
    end
  end
`else
  // Direct path: every capture is published immediately with a strobe.
  always_comb begin
    sample0_d  = sample0_q;
    sample1_d  = sample1_q;
    smpvalid_d = 1'b0;
    if (capture) begin
      sample0_d  = adc0data;
      sample1_d  = adc1data;
      smpvalid_d = 1'b1;
    end
  end
`endif

  // Core state registers; reset wins over any handshake in progress.
  always_ff @(posedge bufclk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= 16'd0;
      wait_q     <= 8'd0;
      adcdav_q   <= 1'b0;
      smpvalid_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      sample0_q  <= 12'd0;
      sample1_q  <= 12'd0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      wait_q     <= wait_d;
      adcdav_q   <= adcdav_d;
      smpvalid_q <= smpvalid_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
      sample0_q  <= sample0_d;
      sample1_q  <= sample1_d;
    end
  end

  assign adcdav   = adcdav_q;
  assign smpvalid = smpvalid_q;
  assign overrun  = overrun_q;
  assign timeout  = timeout_q;
  assign sample0  = sample0_q;
  assign sample1  = sample1_q;

endmodule

// File: tb/tb_ad1_sample_ctrl.sv
// Testbench for ad1_sample_ctrl: directed scenarios with a scoreboard queue of
// expected samples consumed by a monitor on every smpvalid strobe.
// Honours AD1_AVG_EN the same way the design does.
module tb_ad1_sample_ctrl;

  logic        bufclk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        clrflags = 1'b0;
  logic        davadc = 1'b0;
  logic [11:0] adc0data = 12'd0;
  logic [11:0] adc1data = 12'd0;
  logic        adcdav, smpvalid, overrun, timeout;
  logic [11:0] sample0, sample1;

  // second instance with a short period for the overrun scenario
  logic        o_enable = 1'b0;
  logic        o_clrflags = 1'b0;
  logic        o_davadc = 1'b0;
  logic [11:0] o_adc0data = 12'h555;
  logic [11:0] o_adc1data = 12'h0AA;
  logic        o_adcdav, o_smpvalid, o_overrun, o_timeout;
  logic [11:0] o_sample0, o_sample1;

  ad1_sample_ctrl #(.DIV(200), .TMO(100)) u_dut (
    .bufclk(bufclk), .reset(reset), .enable(enable), .clrflags(clrflags),
    .adcdav(adcdav), .davadc(davadc), .adc0data(adc0data), .adc1data(adc1data),
    .sample0(sample0), .sample1(sample1), .smpvalid(smpvalid),
    .overrun(overrun), .timeout(timeout)
  );

  ad1_sample_ctrl #(.DIV(80), .TMO(100)) u_ovr (
    .bufclk(bufclk), .reset(reset), .enable(o_enable), .clrflags(o_clrflags),
    .adcdav(o_adcdav), .davadc(o_davadc), .adc0data(o_adc0data), .adc1data(o_adc1data),
    .sample0(o_sample0), .sample1(o_sample1), .smpvalid(o_smpvalid),
    .overrun(o_overrun), .timeout(o_timeout)
  );

  always #5 bufclk = ~bufclk;

  typedef struct packed {
    logic [11:0] s0;
    logic [11:0] s1;
  } exp_t;

  exp_t        sb_q[$];
  logic [11:0] seq0_q[$];
  logic [11:0] seq1_q[$];
  logic [11:0] def0 = 12'd0;
  logic [11:0] def1 = 12'd0;
  int          conv_mode = 0;   // 0: never acknowledge, 1: acknowledge after ack_dly
  int          ack_dly = 68;
  int          hi_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          smp_count = 0;
  int          last_valid_cyc = 0;
  int          prev_valid_cyc = 0;
  logic        prev_adcdav = 1'b0;

  always @(posedge bufclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [11:0] s0, input logic [11:0] s1);
    exp_t e;
    e.s0 = s0;
    e.s1 = s1;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge bufclk);
    #2;
  endtask

  task automatic wait_adcdav_high(input int budget, output int n);
    n = 0;
    while (!adcdav && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_sb_empty(input string name, input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(name, sb_q.size(), 0);
  endtask

  // Converter model: drives davadc/data on the falling edge.
  initial begin
    forever begin
      @(negedge bufclk);
      if (conv_mode == 1 && adcdav) begin
        if (!davadc) begin
          hi_cnt++;
          if (hi_cnt >= ack_dly) begin
            davadc   = 1'b1;
            adc0data = (seq0_q.size() != 0) ? seq0_q.pop_front() : def0;
            adc1data = (seq1_q.size() != 0) ? seq1_q.pop_front() : def1;
          end
        end
      end else begin
        davadc = 1'b0;
        hi_cnt = 0;
      end
    end
  end

  // Monitor: every strobe pops one expected sample and checks latency.
  initial begin
    exp_t e;
    forever begin
      @(posedge bufclk);
      #1;
      if (smpvalid) begin
        smp_count++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_smpvalid: got sample0=0x%0h sample1=0x%0h expected no strobe (cycle %0d)",
                   sample0, sample1, cyc);
        end else begin
          e = sb_q.pop_front();
          check("sample0", {20'd0, sample0}, {20'd0, e.s0});
          check("sample1", {20'd0, sample1}, {20'd0, e.s1});
        end
        check("smpvalid_latency", {30'd0, prev_adcdav, davadc}, 32'd3);
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
      end
      prev_adcdav = adcdav;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int seen;

    // reset state
    reset = 1'b1;
    repeat (3) step();
    check("rst_adcdav", adcdav, 0);
    check("rst_smpvalid", smpvalid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);
    check("rst_sample0", sample0, 0);
    check("rst_sample1", sample1, 0);
    reset = 1'b0;
    step();

    // periodic sampling, converter acknowledges after 68 cycles
    def0 = 12'hABC;
    def1 = 12'h123;
    conv_mode = 1;
    ack_dly = 68;
`ifdef AD1_AVG_EN
    push_exp(12'hABC, 12'h123);
    enable = 1'b1;
    wait_sb_empty("s1_drain", 1000);
`else
    repeat (3) push_exp(12'hABC, 12'h123);
    enable = 1'b1;
    wait_sb_empty("s1_drain", 800);
    check("s1_period", last_valid_cyc - prev_valid_cyc, 200);
`endif
    enable = 1'b0;
    repeat (5) step();
    check("s1_no_overrun", overrun, 0);
    check("s1_no_timeout", timeout, 0);

    // averaging sequence
    seq0_q = '{12'h100, 12'h101, 12'h102, 12'h104};
    seq1_q = '{12'h010, 12'h020, 12'h030, 12'h040};
`ifdef AD1_AVG_EN
    push_exp(12'h101, 12'h028);
`else
    push_exp(12'h100, 12'h010);
    push_exp(12'h101, 12'h020);
    push_exp(12'h102, 12'h030);
    push_exp(12'h104, 12'h040);
`endif
    enable = 1'b1;
    wait_sb_empty("s2_drain", 1000);
    enable = 1'b0;
    repeat (5) step();
    check("s2_seq_consumed", seq0_q.size(), 0);

    // converter never answers: timeout
    conv_mode = 0;
    base = smp_count;
    enable = 1'b1;
    wait_adcdav_high(300, n);
    check("tmo_req_seen", adcdav, 1);
    enable = 1'b0;
    n = 0;
    while (adcdav && n < 300) begin
      step();
      n++;
    end
    check("tmo_adcdav_cycles", n, 100);
    check("tmo_flag", timeout, 1);
    repeat (3) step();
    check("tmo_no_smpvalid", smp_count - base, 0);
    clrflags = 1'b1;
    step();
    clrflags = 1'b0;
    step();
    check("tmo_clear", timeout, 0);

    // reset in the middle of a request
    enable = 1'b1;
    wait_adcdav_high(300, n);
    check("rst_req_seen", adcdav, 1);
    repeat (10) step();
    reset = 1'b1;
    enable = 1'b0;
    step();
    check("midrst_adcdav", adcdav, 0);
    check("midrst_sample0", sample0, 0);
    check("midrst_sample1", sample1, 0);
    check("midrst_smpvalid", smpvalid, 0);
    check("midrst_timeout", timeout, 0);
    reset = 1'b0;
    step();
    enable = 1'b1;
    wait_adcdav_high(400, n);
    check("midrst_restart_cycles", n, 200);
    enable = 1'b0;
    n = 0;
    while (adcdav && n < 200) begin
      step();
      n++;
    end
    repeat (3) step();
    clrflags = 1'b1;
    step();
    clrflags = 1'b0;
    step();

    // enable dropped during a request: handshake still completes
    conv_mode = 1;
    def0 = 12'h5A5;
    def1 = 12'h3C3;
    base = smp_count;
    enable = 1'b1;
    wait_adcdav_high(300, n);
    check("endrop_req_seen", adcdav, 1);
`ifndef AD1_AVG_EN
    push_exp(12'h5A5, 12'h3C3);
`endif
    enable = 1'b0;
    repeat (100) step();
`ifdef AD1_AVG_EN
    check("endrop_smp_count", smp_count - base, 0);
`else
    check("endrop_smp_count", smp_count - base, 1);
`endif
    check("endrop_drain", sb_q.size(), 0);
    seen = 0;
    repeat (300) begin
      step();
      if (adcdav) seen++;
    end
    check("endrop_adcdav_idle", seen, 0);
`ifndef AD1_AVG_EN
    push_exp(12'h5A5, 12'h3C3);
`endif
    enable = 1'b1;
    wait_adcdav_high(400, n);
    check("endrop_tick_held", n, 200);
    enable = 1'b0;
    wait_sb_empty("endrop_second_drain", 200);
    repeat (10) step();

    // overrun on the short-period instance
    o_enable = 1'b1;
    n = 0;
    while (!o_adcdav && n < 200) begin
      step();
      n++;
    end
    check("ovr_req_seen", o_adcdav, 1);
    o_davadc = 1'b1;
    repeat (150) step();
    check("ovr_flag", o_overrun, 1);
    o_davadc = 1'b0;
    o_enable = 1'b0;
    repeat (5) step();
`ifdef AD1_AVG_EN
    check("ovr_capture", o_sample0, 12'h000);
`else
    check("ovr_capture", o_sample0, 12'h555);
`endif
    o_clrflags = 1'b1;
    step();
    o_clrflags = 1'b0;
    step();
    check("ovr_clear", o_overrun, 0);

    // overrun set while clrflags is held: the set must still show
    o_enable = 1'b1;
    n = 0;
    while (!o_adcdav && n < 200) begin
      step();
      n++;
    end
    o_davadc = 1'b1;
    o_clrflags = 1'b1;
    seen = 0;
    repeat (200) begin
      step();
      if (o_overrun) seen++;
    end
    check("ovr_set_wins", (seen > 0) ? 1 : 0, 1);
    o_clrflags = 1'b0;
    o_davadc = 1'b0;
    o_enable = 1'b0;
    repeat (5) step();

    check("sb_empty_end", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
